// File: rtl/flash_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// flash_pkg : shared types and constants for the flash request arbiter
// Rev 1.0
// ============================================================================
package flash_pkg;

  typedef enum logic [1:0] {
    FL_READ    = 2'd0,
    FL_WRITE   = 2'd1,
    FL_ERASE4K = 2'd2,
    FL_RSVD    = 2'd3
  } flash_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int c_WDOG_W = 16;

endpackage
`default_nettype wire

// File: rtl/flash_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// flash_req_arbiter_if : requester and flash-controller command signals
// Rev 1.0
// ============================================================================
interface flash_req_arbiter_if #(
  parameter int ADDR_W = 24
);

  logic [1:0]          req_valid;
  logic [3:0]          req_cmd;
  logic [2*ADDR_W-1:0] req_addr;
  logic [63:0]         req_wdata;
  logic [1:0]          req_lock;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic                fl_start;
  logic [1:0]          fl_cmd;
  logic [ADDR_W-1:0]   fl_addr;
  logic [31:0]         fl_wdata;
  logic                fl_abort;
  logic                fl_busy;
  logic                fl_done;
  logic [31:0]         fl_rdata;

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata, req_lock,
    input  fl_busy, fl_done, fl_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output fl_start, fl_cmd, fl_addr, fl_wdata, fl_abort
  );

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata, req_lock,
    output fl_busy, fl_done, fl_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  fl_start, fl_cmd, fl_addr, fl_wdata, fl_abort
  );

endinterface
`default_nettype wire

// File: rtl/flash_req_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// flash_rr_pick : combinational two-way pick (lock, fixed priority, round-robin)
// Rev 1.0
// ============================================================================
module flash_rr_pick (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  input  logic       fixed_pri_i,
  input  logic       lock_held_i,
  input  logic       owner_i,
  output logic [1:0] grant_o,
  output logic       grant_any_o
);

  always_comb begin
    grant_o = 2'b00;
    if (lock_held_i) begin
      grant_o = owner_i ? {valid_i[1], 1'b0} : {1'b0, valid_i[0]};
    end else if (valid_i == 2'b11) begin
      // Tie: requester 1 under fixed priority, otherwise the one not served last
      grant_o = (fixed_pri_i || !last_grant_i) ? 2'b10 : 2'b01;
    end else begin
      grant_o = valid_i;
    end
  end

  assign grant_any_o = |grant_o;

endmodule
`default_nettype wire

// File: rtl/flash_req_arbiter.sv
`default_nettype none
// ============================================================================
// flash_req_arbiter : shares one flash command port between two requesters
// Rev 1.0
// ============================================================================
module flash_req_arbiter
  import flash_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ADDR_W         = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               boot_mode,
  flash_req_arbiter_if.slave bus
);

  localparam logic [c_WDOG_W-1:0] c_TMO_LAST = c_WDOG_W'(TIMEOUT_CYCLES - 1);

  arb_state_t          state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic                lock_held_q, lock_held_d;
  logic                err_q, err_d;
  flash_cmd_t          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [c_WDOG_W-1:0] cnt_q, cnt_d;

  logic       w_lock_eff;
  logic [1:0] w_grant;
  logic       w_grant_any;
  logic       w_ready;
  logic       w_start;
  logic       w_abort;
  logic       w_rsp;

  // Lock lapses the same cycle the owner drops req_lock
  assign w_lock_eff = lock_held_q & bus.req_lock[owner_q];

  flash_rr_pick u_pick (
    .valid_i      (bus.req_valid),
    .last_grant_i (last_grant_q),
    .fixed_pri_i  (boot_mode),
    .lock_held_i  (w_lock_eff),
    .owner_i      (owner_q),
    .grant_o      (w_grant),
    .grant_any_o  (w_grant_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lock_held_q  <= 1'b0;
      err_q        <= 1'b0;
      cmd_q        <= FL_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lock_held_q  <= lock_held_d;
      err_q        <= err_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lock_held_d  = lock_held_q;
    err_d        = err_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    w_ready      = 1'b0;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_rsp        = 1'b0;

    case (state_q)
      IDLE: begin
        lock_held_d = w_lock_eff;
        if (w_grant_any) begin
          owner_d      = w_grant[1];
          last_grant_d = w_grant[1];
          cmd_d        = flash_cmd_t'(({2{w_grant[0]}} & bus.req_cmd[1:0]) |
                                      ({2{w_grant[1]}} & bus.req_cmd[3:2]));
          addr_d       = ({ADDR_W{w_grant[0]}} & bus.req_addr[ADDR_W-1:0]) |
                         ({ADDR_W{w_grant[1]}} & bus.req_addr[2*ADDR_W-1:ADDR_W]);
          wdata_d      = ({32{w_grant[0]}} & bus.req_wdata[31:0]) |
                         ({32{w_grant[1]}} & bus.req_wdata[63:32]);
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.fl_busy) begin
          w_ready = 1'b1;
          if (cmd_q == FL_RSVD) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            w_start = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.fl_done) begin
          rdata_d = bus.fl_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == c_TMO_LAST) begin
          w_abort = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        w_rsp       = 1'b1;
        lock_held_d = bus.req_lock[owner_q];
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = {w_ready & owner_q, w_ready & ~owner_q};
  assign bus.rsp_valid = {w_rsp & owner_q, w_rsp & ~owner_q};
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = w_rsp & err_q;
  assign bus.fl_start  = w_start;
  assign bus.fl_cmd    = cmd_q;
  assign bus.fl_addr   = addr_q;
  assign bus.fl_wdata  = wdata_q;
  assign bus.fl_abort  = w_abort;

endmodule
`default_nettype wire

// File: tb/tb_flash_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_flash_req_arbiter : directed self-checking bench for flash_req_arbiter
// Rev 1.0
// ============================================================================
module tb_flash_req_arbiter;

  localparam int ADDR_W = 24;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic boot_mode = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_req_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  flash_req_arbiter #(
    .TIMEOUT_CYCLES (16),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .boot_mode (boot_mode),
    .bus       (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int w, input logic [1:0] cmd, input logic [23:0] addr,
                         input logic [31:0] wdata);
    bus.req_cmd[2*w +: 2]    = cmd;
    bus.req_addr[ADDR_W*w +: ADDR_W] = addr;
    bus.req_wdata[32*w +: 32] = wdata;
  endtask

  // Moves from an arbitrating IDLE cycle into ISSUE and checks the launch
  task automatic issue_chk(input logic w, input logic [23:0] addr, input logic [1:0] cmd);
    tick();
    chk("req_ready", {62'd0, bus.req_ready}, w ? 64'd2 : 64'd1);
    chk("fl_start", {63'd0, bus.fl_start}, 64'd1);
    chk("fl_addr", {40'd0, bus.fl_addr}, {40'd0, addr});
    chk("fl_cmd", {62'd0, bus.fl_cmd}, {62'd0, cmd});
  endtask

  // From ISSUE: one WAIT cycle with fl_done, then check the response
  task automatic resp_chk(input logic w, input logic [31:0] d, input logic [1:0] valid_after);
    tick();
    bus.req_valid = valid_after;
    bus.fl_done   = 1'b1;
    bus.fl_rdata  = d;
    tick();
    bus.fl_done   = 1'b0;
    #1;
    chk("rsp_valid", {62'd0, bus.rsp_valid}, w ? 64'd2 : 64'd1);
    chk("rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, d});
    chk("rsp_err", {63'd0, bus.rsp_err}, 64'd0);
    tick();
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_cmd   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_lock  = 2'b00;
    bus.fl_busy   = 1'b0;
    bus.fl_done   = 1'b0;
    bus.fl_rdata  = '0;

    // Reset state
    tick();
    tick();
    chk("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
    chk("rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
    chk("rst_fl_start", {63'd0, bus.fl_start}, 64'd0);
    chk("rst_fl_addr", {40'd0, bus.fl_addr}, 64'd0);
    chk("rst_fl_abort", {63'd0, bus.fl_abort}, 64'd0);
    rst_n = 1'b1;

    // Single read, fl_done three cycles after fl_start
    set_req(0, 2'd0, 24'h000100, 32'd0);
    bus.req_valid = 2'b01;
    issue_chk(1'b0, 24'h000100, 2'd0);
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("start_one_cycle", {63'd0, bus.fl_start}, 64'd0);
    tick();
    tick();
    bus.fl_done  = 1'b1;
    bus.fl_rdata = 32'hDEADBEEF;
    tick();
    bus.fl_done  = 1'b0;
    #1;
    chk("rd_rsp_valid", {62'd0, bus.rsp_valid}, 64'd1);
    chk("rd_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'hDEADBEEF);
    chk("rd_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
    tick();
    chk("rd_rsp_pulse", {62'd0, bus.rsp_valid}, 64'd0);
    chk("rd_rdata_hold", {32'd0, bus.rsp_rdata}, 64'hDEADBEEF);

    // Round-robin: last grant was 0, so requester 1 leads
    set_req(0, 2'd0, 24'h000010, 32'd0);
    set_req(1, 2'd0, 24'h000020, 32'd0);
    bus.req_valid = 2'b11;
    issue_chk(1'b1, 24'h000020, 2'd0);
    resp_chk(1'b1, 32'h1, 2'b11);
    issue_chk(1'b0, 24'h000010, 2'd0);
    resp_chk(1'b0, 32'h2, 2'b11);
    issue_chk(1'b1, 24'h000020, 2'd0);
    resp_chk(1'b1, 32'h3, 2'b11);
    issue_chk(1'b0, 24'h000010, 2'd0);
    resp_chk(1'b0, 32'h4, 2'b11);

    // Fixed priority to requester 1
    boot_mode = 1'b1;
    issue_chk(1'b1, 24'h000020, 2'd0);
    resp_chk(1'b1, 32'h5, 2'b11);
    issue_chk(1'b1, 24'h000020, 2'd0);
    resp_chk(1'b1, 32'h6, 2'b00);
    boot_mode = 1'b0;

    // Lock: erase then write on requester 1, requester 0 starved meanwhile
    set_req(1, 2'd2, 24'h001000, 32'd0);
    bus.req_lock  = 2'b10;
    bus.req_valid = 2'b10;
    issue_chk(1'b1, 24'h001000, 2'd2);
    tick();
    set_req(1, 2'd1, 24'h002000, 32'h12345678);
    set_req(0, 2'd0, 24'h000200, 32'd0);
    bus.req_valid = 2'b11;
    bus.fl_done   = 1'b1;
    bus.fl_rdata  = 32'd0;
    tick();
    bus.fl_done = 1'b0;
    #1;
    chk("lock_erase_rsp", {62'd0, bus.rsp_valid}, 64'd2);
    tick();
    issue_chk(1'b1, 24'h002000, 2'd1);
    chk("lock_wdata", {32'd0, bus.fl_wdata}, 64'h12345678);
    resp_chk(1'b1, 32'h0, 2'b01);
    tick();
    chk("lock_starve_a", {62'd0, bus.req_ready}, 64'd0);
    tick();
    chk("lock_starve_b", {62'd0, bus.req_ready}, 64'd0);
    bus.req_lock = 2'b00;
    issue_chk(1'b0, 24'h000200, 2'd0);
    resp_chk(1'b0, 32'hA5A5A5A5, 2'b00);

    // Timeout: abort on the 16th WAIT cycle
    set_req(0, 2'd0, 24'h000500, 32'd0);
    bus.req_valid = 2'b01;
    issue_chk(1'b0, 24'h000500, 2'd0);
    tick();
    bus.req_valid = 2'b00;
    repeat (13) tick();
    tick();
    chk("tmo_no_abort_15", {63'd0, bus.fl_abort}, 64'd0);
    tick();
    chk("tmo_abort_16", {63'd0, bus.fl_abort}, 64'd1);
    chk("tmo_no_rsp_yet", {62'd0, bus.rsp_valid}, 64'd0);
    tick();
    chk("tmo_rsp_valid", {62'd0, bus.rsp_valid}, 64'd1);
    chk("tmo_rsp_err", {63'd0, bus.rsp_err}, 64'd1);
    chk("tmo_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
    chk("tmo_abort_pulse", {63'd0, bus.fl_abort}, 64'd0);
    tick();

    // Reserved command: error response at N+2, no launch
    set_req(0, 2'd3, 24'h000555, 32'd0);
    bus.req_valid = 2'b01;
    tick();
    chk("rsv_ready", {62'd0, bus.req_ready}, 64'd1);
    chk("rsv_no_start", {63'd0, bus.fl_start}, 64'd0);
    bus.req_valid = 2'b00;
    tick();
    chk("rsv_rsp_valid", {62'd0, bus.rsp_valid}, 64'd1);
    chk("rsv_rsp_err", {63'd0, bus.rsp_err}, 64'd1);
    chk("rsv_no_start_2", {63'd0, bus.fl_start}, 64'd0);
    tick();

    // Busy stall in ISSUE
    bus.fl_busy = 1'b1;
    set_req(1, 2'd0, 24'h000300, 32'd0);
    bus.req_valid = 2'b10;
    tick();
    chk("busy_ready_lo", {62'd0, bus.req_ready}, 64'd0);
    chk("busy_start_lo", {63'd0, bus.fl_start}, 64'd0);
    repeat (3) tick();
    tick();
    chk("busy_ready_lo_5", {62'd0, bus.req_ready}, 64'd0);
    tick();
    bus.fl_busy = 1'b0;
    #1;
    chk("busy_fall_ready", {62'd0, bus.req_ready}, 64'd2);
    chk("busy_fall_start", {63'd0, bus.fl_start}, 64'd1);
    chk("busy_fall_addr", {40'd0, bus.fl_addr}, 64'h000300);
    resp_chk(1'b1, 32'h11112222, 2'b00);

    // Reset while in WAIT
    set_req(0, 2'd1, 24'h000600, 32'h0BADF00D);
    bus.req_valid = 2'b01;
    issue_chk(1'b0, 24'h000600, 2'd1);
    tick();
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    chk("mid_rst_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
    chk("mid_rst_fl_addr", {40'd0, bus.fl_addr}, 64'd0);
    chk("mid_rst_fl_cmd", {62'd0, bus.fl_cmd}, 64'd0);
    chk("mid_rst_fl_wdata", {32'd0, bus.fl_wdata}, 64'd0);
    chk("mid_rst_abort", {63'd0, bus.fl_abort}, 64'd0);
    rst_n = 1'b1;
    set_req(0, 2'd0, 24'h000700, 32'd0);
    bus.req_valid = 2'b01;
    issue_chk(1'b0, 24'h000700, 2'd0);
    resp_chk(1'b0, 32'hCAFEF00D, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flash_req_arbiter.md
# flash_req_arbiter

Shares the single flash command port of the SPI flash controller between two requesters: requester 0, the AHB-side fetch/data path, and requester 1, the serial bootloader engine. It arbitrates, issues one flash command at a time and waits for completion under a timeout watchdog. It returns the response to the winner and can hold the grant for multi-command sequences (erase, then program). It sits between the requesters and the flash controller's command interface.

## Interface
- TIMEOUT_CYCLES, 65535: max cycles waiting for fl_done before abort; 16-bit counter.
- ADDR_W, 24: flash byte address width.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- boot_mode  in  1  1: requester 1 has fixed priority; 0: round-robin.
- req_valid  in  2  per-requester command valid; held with payload until accepted.
- req_cmd  in  4  2 bits per requester, [2i+1:2i]: 0 READ, 1 WRITE, 2 ERASE4K, 3 reserved.
- req_addr  in  2*ADDR_W  per-requester address, [ADDR_W*i +: ADDR_W].
- req_wdata  in  64  per-requester write word, [32i +: 32].
- req_lock  in  2  keep grant after the current command completes.
- req_ready  out  2  acceptance; transfer = valid & ready.
- rsp_valid  out  2  one-cycle response strobe to the owning requester.
- rsp_rdata  out  32  read data, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- fl_start  out  1  one-cycle command launch to the flash controller.
- fl_cmd  out  2  command code, stable from fl_start until fl_done or abort.
- fl_addr  out  ADDR_W  command address, stable likewise.
- fl_wdata  out  32  command write data, stable likewise.
- fl_abort  out  1  one-cycle pulse on timeout.
- fl_busy  in  1  flash controller busy.
- fl_done  in  1  one-cycle completion strobe from the flash controller.
- fl_rdata  in  32  read data, valid with fl_done.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration. Eligible requesters are those with req_valid set.
  - While lock_held, only the owner is eligible.
  - boot_mode=1: requester 1 wins any tie.
  - boot_mode=0: the requester other than last_grant wins the tie.
  - On a winner: register owner, cmd, addr and wdata into the fl_* outputs, update last_grant, go to ISSUE.
- ISSUE:
  - fl_busy=1: stay in ISSUE, all outputs low.
  - fl_busy=0 and cmd≠3: req_ready[owner]=1 and fl_start=1 for exactly one cycle, then go to WAIT.
  - cmd=3: req_ready[owner]=1 and fl_start=0, set err, go to RESP.
- WAIT:
  - Watchdog counter cleared on entry, increments each cycle.
  - fl_done: capture fl_rdata, err=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without fl_done: fl_abort pulse, err=1, rdata=0, go to RESP.
  - fl_done and timeout in the same cycle: fl_done wins, no abort.
- RESP: rsp_valid[owner]=1 for one cycle with rsp_rdata and rsp_err. lock_held <= req_lock[owner]. Go to IDLE.
- Lock: while lock_held, the other requester is starved. Dropping req_lock[owner] in IDLE clears lock_held in the same cycle, and normal arbitration resumes that cycle.
- rsp_rdata holds its last value between responses; it is 0 after error responses.

## Timing
- Reset: state IDLE, last_grant=1 (requester 0 wins the first tie), lock_held=0, counter=0. All outputs 0, including rsp_rdata, fl_cmd, fl_addr and fl_wdata.
- Reset mid-operation: return to IDLE immediately. No fl_abort and no rsp_valid are generated.
- Latency, with fl_busy=0:
  - req_valid seen in IDLE at cycle N.
  - req_ready and fl_start at N+1.
  - WAIT from N+2.
  - fl_done at cycle M gives rsp_valid at M+1.
  - IDLE at M+2, so the next arbitration happens at M+2.
- Reserved command: rsp_valid with err=1 at N+2.
- req_valid dropped before acceptance: not permitted by the protocol; behaviour undefined and not checked.
- fl_done outside WAIT is ignored.

## Structure
- Shared package flash_pkg:
  - flash_cmd_t enum: FL_READ, FL_WRITE, FL_ERASE4K, FL_RSVD.
  - arb_state_t enum: IDLE, ISSUE, WAIT, RESP.
  - Constant for the watchdog counter width (16).
- Sub-module flash_rr_pick: combinational 2-way pick. Inputs: valid[1:0], last_grant, fixed_pri, lock_held, owner. Outputs: grant one-hot and grant_any.
- Top module holds the FSM, payload registers, watchdog counter and response registers.

## Test plan
- Single read: req0 READ addr 0x000100. fl_start at N+1 with fl_addr 0x000100. fl_done with fl_rdata 0xDEADBEEF three cycles later gives rsp_valid[0], rsp_rdata 0xDEADBEEF, rsp_err 0.
- Round-robin: both requesters valid continuously, boot_mode=0. Grants alternate 0,1,0,1. With boot_mode=1, every grant goes to 1 while req1 is valid.
- Lock: req1 ERASE4K with req_lock[1]=1, then WRITE 0x12345678. req0 held valid is not granted until req_lock[1] drops. After that req0 is granted next.
- Timeout: TIMEOUT_CYCLES=16, fl_done never asserted. fl_abort at the 16th WAIT cycle, then rsp_valid with rsp_err 1 and rsp_rdata 0.
- Busy and reserved: fl_busy=1 for 5 cycles keeps req_ready and fl_start low, and they assert the cycle fl_busy falls. cmd=3 gives rsp_err 1 at N+2 with no fl_start.
- Reset in WAIT: rst_n low for one cycle returns all outputs to 0 with no rsp_valid. A subsequent read completes normally.
